hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline's two-stage forwarding logic.
- Generates operand-forward selects for EX from NUM_FWD_STAGES downstream stages, with nearest stage taking priority.
- Detects load-use hazards and tracks outstanding multi-cycle (MUL/DIV) writebacks in a register scoreboard, raising an ID stall and EX bubble when needed.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- NUM_FWD_STAGES, 2, number of forwarding source stages; index 0 = nearest (EX/MEM).
- REG_AW, 5, register address width; NUM_REGS = 2**REG_AW.
- MAX_PENDING, 4, maximum outstanding multi-cycle ops (1..NUM_REGS-1).
- BYPASS_DONE, 1, if 1, a register completing via mc_done this cycle does not stall ID (register file is write-first).
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_rs1  in  REG_AW  source 1 of the instruction in EX.
- ex_rs2  in  REG_AW  source 2 of the instruction in EX.
- fwd_regwrite  in  NUM_FWD_STAGES  stage k writes a register.
- fwd_rd  in  NUM_FWD_STAGES*REG_AW  destination of stage k, at bits [k*REG_AW +: REG_AW].
- forward_a  out  SEL_W=$clog2(NUM_FWD_STAGES+1)  0 = register file, k+1 = stage k.
- forward_b  out  SEL_W  same encoding for rs2.
- id_rs1, id_rs2  in  REG_AW  ID-stage sources.
- id_rs1_used, id_rs2_used  in  1  the source is actually read.
- id_rd  in  REG_AW  ID-stage destination.
- id_regwrite  in  1  ID instruction writes id_rd.
- id_is_mc  in  1  ID instruction is a multi-cycle op.
- idex_mem_read  in  1  instruction in ID/EX is a load.
- idex_rd  in  REG_AW  destination of that load.
- mc_issue  in  1  multi-cycle op leaves EX this cycle.
- mc_issue_rd  in  REG_AW  its destination.
- mc_done  in  1  multi-cycle result written back this cycle.
- mc_done_rd  in  REG_AW  destination of that result.
- stall  out  1  hold PC and IF/ID.
- flush_ex  out  1  insert bubble into ID/EX; always equals stall.
- sb_full  out  1  outstanding count == MAX_PENDING.
- stall_count  out  CNT_W  cycles in which stall was high.

Behaviour:
- Forwarding (combinational):
  - For each of rs1 and rs2, choose the lowest k with fwd_regwrite[k], fwd_rd_k != 0 and fwd_rd_k == ex_rsX; output k+1.
  - If no stage matches, output 0.
  - Source register 0 always yields 0.
- Load-use: lu = idex_mem_read && idex_rd != 0 && ((id_rs1_used && id_rs1 == idex_rd) || (id_rs2_used && id_rs2 == idex_rd)).
- Scoreboard: registered pending[NUM_REGS-1:0]; bit 0 is hard-wired 0.
  - Set on mc_issue for mc_issue_rd != 0.
  - Clear on mc_done for mc_done_rd.
  - Issue and done in the same cycle: apply both; if both name the same rd, the set wins.
- RAW stall term: a used source s with pending[s] = 1, except when BYPASS_DONE = 1 and mc_done && mc_done_rd == s in the same cycle.
- WAW stall term: id_regwrite && id_rd != 0 && pending[id_rd], with the same BYPASS_DONE exception.
- Structural stall term: id_is_mc && sb_full && !mc_done.
- stall = lu | RAW term | WAW term | structural term. It is combinational, so the pipeline sees it in the same cycle.
- Outstanding counter (width $clog2(MAX_PENDING+1)):
  - +1 on valid issue, -1 on done, unchanged when both occur.
  - Issue while full is a protocol error: the counter is not changed; assertion in simulation.
  - Done while zero is likewise ignored; assertion in simulation.
- stall_count increments each cycle stall = 1 and saturates at all-ones.
- Reset: pending = 0, counter = 0, sb_full = 0, stall_count = 0. With all inputs low, forward_a = forward_b = 0 and stall = flush_ex = 0.
- Reset assertion mid-operation clears all state immediately; in-flight multi-cycle ops are forgotten.

Decomposition:
- Package hazard_pkg holds:
  - REG_AW default;
  - the forward-select encoding constants FWD_RF = 0 and FWD_STAGE_BASE = 1;
  - function fwd_sel_w(n) returning $clog2(n+1).
- Natural sub-module: mc_scoreboard, holding the pending bits, outstanding counter, sb_full and the RAW/WAW/structural query logic. The top level holds the forwarding priority mux, load-use detection and stall counter.

Test Plan:
1. NUM_FWD_STAGES = 3; stages 0 and 2 both write x5; ex_rs1 = 5 -> forward_a = 1. Then stage 0 regwrite = 0 -> forward_a = 3. ex_rs2 = 0 with rd = 0 writing -> forward_b = 0.
2. idex_mem_read = 1, idex_rd = 7; id_rs2 = 7 with id_rs2_used = 1 -> stall = flush_ex = 1 for that cycle; stall_count goes 0 -> 1. Same case with id_rs2_used = 0 -> stall = 0.
3. mc_issue rd = 9; next cycle id_rs1 = 9 -> stall held until the mc_done rd = 9 cycle. In that cycle stall = 0 with BYPASS_DONE = 1, and stall = 1 with BYPASS_DONE = 0.
4. Issue 4 ops (rd 1..4) -> sb_full = 1. id_is_mc = 1 -> stall = 1. mc_done rd = 2 in the same cycle -> stall = 0.
5. mc_issue rd = 3 and mc_done rd = 3 in the same cycle -> pending[3] = 1 and count unchanged. id_rd = 3 with id_regwrite -> WAW stall = 1.
6. Assert rst_n low mid-stall with pending bits set -> pending, count and stall_count clear asynchronously; stall = 0 after release with idle inputs.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the hazard/forwarding unit.
package hazard_pkg;

    localparam int DEF_REG_AW     = 5;
    localparam int FWD_RF         = 0;
    localparam int FWD_STAGE_BASE = 1;

    function automatic int fwd_sel_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mc_scoreboard.sv
// Pending-writeback scoreboard for multi-cycle ops plus the RAW/WAW/structural
// hazard queries made by the ID stage.
module mc_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW      = DEF_REG_AW,
    parameter int MAX_PENDING = 4,
    parameter int BYPASS_DONE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mc_issue,
    input  logic [REG_AW-1:0] mc_issue_rd,
    input  logic              mc_done,
    input  logic [REG_AW-1:0] mc_done_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_mc,
    output logic              sb_full,
    output logic              sb_hazard
);

    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int CW       = $clog2(MAX_PENDING + 1);

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pending_next_s;
    logic [CW-1:0]       count_r;
    logic [CW-1:0]       count_next_s;
    logic                full_r;
    logic                issue_valid_s;
    logic                empty_s;
    logic                byp_rs1_s;
    logic                byp_rs2_s;
    logic                byp_rd_s;
    logic                raw_s;
    logic                waw_s;
    logic                struct_s;

    assign issue_valid_s = mc_issue && (mc_issue_rd != '0);
    assign empty_s       = (count_r == '0);

    // Next pending vector: set is applied after clear so a same-rd issue wins.
    always_comb begin
        pending_next_s = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            pending_next_s[i] = (issue_valid_s && (mc_issue_rd == REG_AW'(i))) ? 1'b1 :
                                (mc_done && (mc_done_rd == REG_AW'(i)))       ? 1'b0 :
                                pending_r[i];
        end
    end

    // Outstanding-op count; illegal issue-when-full / done-when-empty are ignored.
    always_comb begin
        count_next_s = count_r;
        case ({issue_valid_s, mc_done})
            2'b10: begin
                if (!full_r) count_next_s = count_r + CW'(1);
                else         count_next_s = count_r;
            end
            2'b01: begin
                if (!empty_s) count_next_s = count_r - CW'(1);
                else          count_next_s = count_r;
            end
            default: count_next_s = count_r;
        endcase
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= '0;
            count_r   <= '0;
            full_r    <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            count_r   <= count_next_s;
            full_r    <= (count_next_s == CW'(MAX_PENDING));
        end
    end

    // A write-first register file lets a completing result satisfy ID directly.
    always_comb begin
        byp_rs1_s = (BYPASS_DONE != 0) && mc_done && (mc_done_rd == id_rs1);
        byp_rs2_s = (BYPASS_DONE != 0) && mc_done && (mc_done_rd == id_rs2);
        byp_rd_s  = (BYPASS_DONE != 0) && mc_done && (mc_done_rd == id_rd);
        raw_s     = (id_rs1_used && pending_r[id_rs1] && !byp_rs1_s) ||
                    (id_rs2_used && pending_r[id_rs2] && !byp_rs2_s);
        waw_s     = id_regwrite && (id_rd != '0) && pending_r[id_rd] && !byp_rd_s;
        struct_s  = id_is_mc && full_r && !mc_done;
    end

    assign sb_full   = full_r;
    assign sb_hazard = raw_s || waw_s || struct_s;

    mc_scoreboard_checker u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid_s),
        .done        (mc_done),
        .full        (full_r),
        .empty       (empty_s)
    );

endmodule

// File: rtl/mc_scoreboard_checker.sv
// Simulation-only protocol checks on the multi-cycle scoreboard counter.
module mc_scoreboard_checker (
    input logic clk,
    input logic rst_n,
    input logic issue_valid,
    input logic done,
    input logic full,
    input logic empty
);

    a_issue_while_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(issue_valid && !done && full));

    a_done_while_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(done && !issue_valid && empty));

endmodule

// File: rtl/hazard_forward_unit.sv
// EX operand forwarding with nearest-stage priority, load-use detection,
// multi-cycle scoreboard stalls and a saturating stall-cycle counter.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int REG_AW         = DEF_REG_AW,
    parameter int MAX_PENDING    = 4,
    parameter int BYPASS_DONE    = 1,
    parameter int CNT_W          = 32,
    localparam int SEL_W         = fwd_sel_w(NUM_FWD_STAGES)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [REG_AW-1:0]                ex_rs1,
    input  logic [REG_AW-1:0]                ex_rs2,
    input  logic [NUM_FWD_STAGES-1:0]        fwd_regwrite,
    input  logic [NUM_FWD_STAGES*REG_AW-1:0] fwd_rd,
    output logic [SEL_W-1:0]                 forward_a,
    output logic [SEL_W-1:0]                 forward_b,
    input  logic [REG_AW-1:0]                id_rs1,
    input  logic [REG_AW-1:0]                id_rs2,
    input  logic                             id_rs1_used,
    input  logic                             id_rs2_used,
    input  logic [REG_AW-1:0]                id_rd,
    input  logic                             id_regwrite,
    input  logic                             id_is_mc,
    input  logic                             idex_mem_read,
    input  logic [REG_AW-1:0]                idex_rd,
    input  logic                             mc_issue,
    input  logic [REG_AW-1:0]                mc_issue_rd,
    input  logic                             mc_done,
    input  logic [REG_AW-1:0]                mc_done_rd,
    output logic                             stall,
    output logic                             flush_ex,
    output logic                             sb_full,
    output logic [CNT_W-1:0]                 stall_count
);

    logic [NUM_FWD_STAGES-1:0] hit_a_s;
    logic [NUM_FWD_STAGES-1:0] hit_b_s;
    logic                      lu_s;
    logic                      sb_hazard_s;
    logic [CNT_W-1:0]          stall_count_r;

    // Per-stage match; a zero destination never forwards.
    always_comb begin
        hit_a_s = '0;
        hit_b_s = '0;
        for (int k = 0; k < NUM_FWD_STAGES; k++) begin
            hit_a_s[k] = fwd_regwrite[k] && (fwd_rd[k*REG_AW +: REG_AW] != '0) &&
                         (fwd_rd[k*REG_AW +: REG_AW] == ex_rs1);
            hit_b_s[k] = fwd_regwrite[k] && (fwd_rd[k*REG_AW +: REG_AW] != '0) &&
                         (fwd_rd[k*REG_AW +: REG_AW] == ex_rs2);
        end
    end

    // Scan far-to-near so the nearest matching stage overrides.
    always_comb begin
        forward_a = SEL_W'(FWD_RF);
        forward_b = SEL_W'(FWD_RF);
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            forward_a = hit_a_s[k] ? SEL_W'(FWD_STAGE_BASE + k) : forward_a;
            forward_b = hit_b_s[k] ? SEL_W'(FWD_STAGE_BASE + k) : forward_b;
        end
    end

    assign lu_s = idex_mem_read && (idex_rd != '0) &&
                  ((id_rs1_used && (id_rs1 == idex_rd)) ||
                   (id_rs2_used && (id_rs2 == idex_rd)));

    mc_scoreboard #(
        .REG_AW      (REG_AW),
        .MAX_PENDING (MAX_PENDING),
        .BYPASS_DONE (BYPASS_DONE)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .mc_issue    (mc_issue),
        .mc_issue_rd (mc_issue_rd),
        .mc_done     (mc_done),
        .mc_done_rd  (mc_done_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_is_mc    (id_is_mc),
        .sb_full     (sb_full),
        .sb_hazard   (sb_hazard_s)
    );

    assign stall    = lu_s || sb_hazard_s;
    assign flush_ex = stall;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= '0;
        end else if (stall && (stall_count_r != '1)) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;

endmodule
